// File: rtl/counter_seq_monitor_pkg.sv
// rtl/counter_seq_monitor_pkg.sv - state encodings for the counter sequence monitor
package counter_seq_monitor_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ACQUIRE = 2'd1,
      ST_LOCKED  = 2'd2
   } mon_state_t;

endpackage

// File: rtl/counter_seq_monitor.sv
// rtl/counter_seq_monitor.sv - locks onto a +1 counter sequence, flags breaks, counts errors and wraps
module counter_seq_monitor
   import counter_seq_monitor_pkg::*;
#(
   parameter int WIDTH      = 4,
   parameter int ERR_CNT_W  = 8,
   parameter int RESYNC_LEN = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 sample_en,
   input  logic [WIDTH-1:0]     q_in,
   output logic                 locked,
   output logic                 err_pulse,
   output logic                 wrap_pulse,
   output logic [ERR_CNT_W-1:0] err_count,
   output logic [ERR_CNT_W-1:0] wrap_count,
   output logic [WIDTH-1:0]     exp_value,
   output logic [WIDTH-1:0]     bad_value
);

   localparam int GW = (RESYNC_LEN < 2) ? 1 : $clog2(RESYNC_LEN + 1);
   localparam logic [GW-1:0] RUN_TARGET = GW'(RESYNC_LEN);

   mon_state_t       state, next_state;
   logic [WIDTH-1:0] expected;
   logic [GW-1:0]    good_run;
   logic [GW-1:0]    good_run_next;
   logic             match;
   logic             do_seed, do_adv, do_err, do_wrap, do_run;

   assign match         = (q_in == expected);
   assign good_run_next = good_run + 1'b1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= ST_IDLE;
         locked <= 1'b0;
      end else begin
         state  <= next_state;
         locked <= (next_state == ST_LOCKED);
      end
   end

   always_comb begin
      next_state = state;
      do_seed    = 1'b0;
      do_adv     = 1'b0;
      do_err     = 1'b0;
      do_wrap    = 1'b0;
      do_run     = 1'b0;
      if (sample_en) begin
         case (state)
            ST_IDLE: begin
               do_seed    = 1'b1;
               next_state = ST_ACQUIRE;
            end
            ST_ACQUIRE: begin
               if (match) begin
                  do_adv = 1'b1;
                  do_run = 1'b1;
                  if (good_run_next == RUN_TARGET)
                     next_state = ST_LOCKED;
               end else begin
                  do_seed = 1'b1;
               end
            end
            ST_LOCKED: begin
               if (match) begin
                  do_adv  = 1'b1;
                  do_wrap = (q_in == '0);
               end else begin
                  do_err     = 1'b1;
                  do_seed    = 1'b1;
                  next_state = ST_ACQUIRE;
               end
            end
            default: next_state = ST_IDLE;
         endcase
      end
   end

   // Counters stick at all-ones once saturated; only rst clears them.
   always_ff @(posedge clk) begin
      if (rst) begin
         expected   <= '0;
         good_run   <= '0;
         err_pulse  <= 1'b0;
         wrap_pulse <= 1'b0;
         err_count  <= '0;
         wrap_count <= '0;
         exp_value  <= '0;
         bad_value  <= '0;
      end else begin
         err_pulse  <= do_err;
         wrap_pulse <= do_wrap;
         if (do_seed) begin
            expected <= q_in + 1'b1;
            good_run <= '0;
         end
         if (do_adv)
            expected <= expected + 1'b1;
         if (do_run)
            good_run <= good_run_next;
         if (do_err) begin
            exp_value <= expected;
            bad_value <= q_in;
            if (err_count != '1)
               err_count <= err_count + 1'b1;
         end
         if (do_wrap && (wrap_count != '1))
            wrap_count <= wrap_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_counter_seq_monitor.sv
// tb/tb_counter_seq_monitor.sv - scoreboard bench for counter_seq_monitor
module tb_counter_seq_monitor;

   typedef struct {
      logic       lk;
      logic       ep;
      logic       wp;
      logic [7:0] ec;
      logic [7:0] wc;
      logic [3:0] ev;
      logic [3:0] bv;
      logic [1:0] ec2;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       sample_en = 1'b0;
   logic [3:0] q_in = '0;

   logic       locked, err_pulse, wrap_pulse;
   logic [7:0] err_count, wrap_count;
   logic [3:0] exp_value, bad_value;
   logic       s_locked, s_err_pulse, s_wrap_pulse;
   logic [1:0] s_err_count, s_wrap_count;
   logic [3:0] s_exp_value, s_bad_value;

   exp_t sb_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   logic       e_lk, e_ep, e_wp;
   logic [7:0] e_ec, e_wc;
   logic [3:0] e_ev, e_bv;

   always #10 clk = ~clk;

   counter_seq_monitor #(.WIDTH(4), .ERR_CNT_W(8), .RESYNC_LEN(2)) dut (
      .clk(clk), .rst(rst), .sample_en(sample_en), .q_in(q_in),
      .locked(locked), .err_pulse(err_pulse), .wrap_pulse(wrap_pulse),
      .err_count(err_count), .wrap_count(wrap_count),
      .exp_value(exp_value), .bad_value(bad_value)
   );

   counter_seq_monitor #(.WIDTH(4), .ERR_CNT_W(2), .RESYNC_LEN(2)) dut_sat (
      .clk(clk), .rst(rst), .sample_en(sample_en), .q_in(q_in),
      .locked(s_locked), .err_pulse(s_err_pulse), .wrap_pulse(s_wrap_pulse),
      .err_count(s_err_count), .wrap_count(s_wrap_count),
      .exp_value(s_exp_value), .bad_value(s_bad_value)
   );

   task automatic chk(input string name, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
      end
   endtask

   // Monitor: every edge's response is compared against the entry queued for it.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("locked",     int'(locked),     int'(e.lk));
            chk("err_pulse",  int'(err_pulse),  int'(e.ep));
            chk("wrap_pulse", int'(wrap_pulse), int'(e.wp));
            chk("err_count",  int'(err_count),  int'(e.ec));
            chk("wrap_count", int'(wrap_count), int'(e.wc));
            chk("exp_value",  int'(exp_value),  int'(e.ev));
            chk("bad_value",  int'(bad_value),  int'(e.bv));
            chk("sat_err_count", int'(s_err_count), int'(e.ec2));
         end
      end
   end

   task automatic step(input logic r, input logic en, input logic [3:0] v);
      exp_t e;
      @(negedge clk);
      rst       = r;
      sample_en = en;
      q_in      = v;
      e.lk  = e_lk;
      e.ep  = e_ep;
      e.wp  = e_wp;
      e.ec  = e_ec;
      e.wc  = e_wc;
      e.ev  = e_ev;
      e.bv  = e_bv;
      e.ec2 = (e_ec > 8'd3) ? 2'd3 : e_ec[1:0];
      sb_q.push_back(e);
   endtask

   task automatic clear_exp();
      e_lk = 0; e_ep = 0; e_wp = 0;
      e_ec = 0; e_wc = 0; e_ev = 0; e_bv = 0;
   endtask

   initial begin
      logic [3:0] cur, g, v;
      int budget;
      clear_exp();

      // reset with random inputs, then release
      step(1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      step(1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      step(0, 0, 4'd9);

      // acquire and lock on 0,1,2
      step(0, 1, 4'd0);
      step(0, 1, 4'd1);
      e_lk = 1;
      step(0, 1, 4'd2);

      // run through the wrap
      for (int i = 3; i <= 15; i++) step(0, 1, 4'(i));
      e_wp = 1; e_wc = 1;
      step(0, 1, 4'd0);
      e_wp = 0;
      step(0, 0, 4'd9);
      step(0, 1, 4'd1);

      // glitch: expected 6, received 7
      for (int i = 2; i <= 5; i++) step(0, 1, 4'(i));
      e_ep = 1; e_ec = 1; e_ev = 4'd6; e_bv = 4'd7; e_lk = 0;
      step(0, 1, 4'd7);
      e_ep = 0;
      step(0, 1, 4'd8);
      e_lk = 1;
      step(0, 1, 4'd9);

      // four more lock+glitch rounds saturate the narrow counter
      cur = 4'd10;
      for (int k = 0; k < 4; k++) begin
         g = cur + 4'd2;
         e_ep = 1; e_ec = e_ec + 1; e_ev = cur; e_bv = g; e_lk = 0;
         step(0, 1, g);
         e_ep = 0;
         step(0, 1, g + 4'd1);
         e_lk = 1;
         step(0, 1, g + 4'd2);
         cur = g + 4'd3;
      end

      // idle while locked: everything holds
      for (int i = 0; i < 10; i++) step(0, 0, ~cur);
      step(0, 1, cur);
      cur = cur + 4'd1;

      // reset during a sample
      clear_exp();
      step(1, 1, cur);

      // acquire mismatch reseeds silently, then a live counter locks on 0 without a wrap
      step(0, 1, 4'd4);
      step(0, 1, 4'd14);
      v = 4'd15;
      for (int i = 0; i < 40; i++) begin
         e_lk = (i >= 1);
         e_wp = (v == 4'd0) && (i > 1);
         if (e_wp) e_wc = e_wc + 1;
         step(0, 1, v);
         v = v + 4'd1;
      end
      e_wp = 0;
      step(0, 0, 4'd0);

      budget = 20;
      while (sb_q.size() > 0 && budget > 0) begin
         @(posedge clk);
         budget--;
      end
      #2;
      if (sb_q.size() > 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
